wvr_drain_seq: RTL and testbench

//  Element-serial read sequencer for the wide vector register file. Accepts one drain command
//  (base register, VL), walks the file's single 32-bit combinational read port one element per

---
 rtl/wvr_pkg.sv | 25 ++
 rtl/wvr_out_slot.sv | 41 ++++
 rtl/wvr_drain_seq.sv | 132 +++++++++++++
 tb/tb_wvr_drain_seq.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wvr_pkg.sv
// Shared definitions for the wide vector register file drain sequencer:
// VL encodings, element-count helper and the sequencer state type.
package wvr_pkg;

  localparam logic [1:0] VL_1   = 2'b00;
  localparam logic [1:0] VL_4   = 2'b01;
  localparam logic [1:0] VL_16  = 2'b10;
  localparam logic [1:0] VL_RSV = 2'b11;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  // Number of elements a command moves; the reserved encoding moves none.
  function automatic logic [4:0] vl_count(input logic [1:0] vl);
    case (vl)
      VL_1:    vl_count = 5'd1;
      VL_4:    vl_count = 5'd4;
      VL_16:   vl_count = 5'd16;
      default: vl_count = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/wvr_out_slot.sv
// Single-entry output register for the drain sequencer. Holds one element
// plus its last marker; the producer only loads it when it is empty or being
// drained in the same cycle, so contents stay stable while stalled.
module wvr_out_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  // Fill on load, empty when the consumer takes the element and nothing new arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/wvr_drain_seq.sv
// Element-serial read sequencer for the wide vector register file.
// Takes one drain command (base, VL), walks the file's combinational read
// port one element per cycle and streams elements over valid/ready.
// Optional build macro WVR_SEQ_STRIDE_EN adds a per-command register stride
// (cmd_stride); without it the stride is fixed at 1.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising clock edge; once valid is raised the payload is held
// unchanged until that transfer. cmd_ready does not depend on cmd_valid, and
// out_valid does not depend on out_ready.
module wvr_drain_seq
  import wvr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [1:0]        cmd_vl,
`ifdef WVR_SEQ_STRIDE_EN
  input  logic [ADDR_W-1:0] cmd_stride,
`endif
  output logic [ADDR_W-1:0] wvr_ra,
  input  logic [DATA_W-1:0] wvr_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err_vl
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] ra_q;
  logic [4:0]        cnt_q;
  logic [4:0]        last_idx_q;
  logic              rsv_q;
  logic [ADDR_W-1:0] stride;

  logic accept;
  logic slot_free;
  logic capture;
  logic cap_last;

`ifdef WVR_SEQ_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  // Stride is a command field, so it is captured only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q <= '0;
    end else if (accept) begin
      stride_q <= cmd_stride;
    end
  end

  assign stride = stride_q;
`else
  assign stride = ADDR_W'(1);
`endif

  // A new command is only taken once the previous one is fully drained,
  // including the cycle its final element (or reserved-VL pulse) is reported.
  assign cmd_ready = (state_q == SEQ_IDLE) && !out_valid && !rsv_q;
  assign accept    = cmd_valid && cmd_ready;
  assign slot_free = !out_valid || out_ready;
  assign capture   = (state_q == SEQ_RUN) && slot_free;
  assign cap_last  = capture && (cnt_q == last_idx_q);

  // Sequencer FSM and address generator; the address only moves on capture,
  // so a stalled slot freezes the read port on the pending element.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      ra_q       <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
      rsv_q      <= 1'b0;
    end else begin
      rsv_q <= accept && (cmd_vl == VL_RSV);
      case (state_q)
        SEQ_IDLE: begin
          if (accept && (cmd_vl != VL_RSV)) begin
            state_q    <= SEQ_RUN;
            ra_q       <= cmd_base;
            cnt_q      <= '0;
            last_idx_q <= vl_count(cmd_vl) - 5'd1;
          end
        end
        SEQ_RUN: begin
          if (capture) begin
            ra_q <= ra_q + stride;
            if (cap_last) begin
              state_q <= SEQ_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  wvr_out_slot #(
    .DATA_W (DATA_W)
  ) u_slot (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (capture),
    .data_i  (wvr_rd),
    .last_i  (cap_last),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .last_o  (out_last)
  );

  assign wvr_ra = ra_q;

  // Completion is reported in the cycle the final element is handed over;
  // busy covers everything from the cycle after accept up to that point.
  assign done   = (out_valid && out_ready && out_last) || rsv_q;
  assign err_vl = rsv_q;
  assign busy   = (state_q == SEQ_RUN) || (out_valid && !(out_ready && out_last)) || rsv_q;

endmodule

// File: tb/tb_wvr_drain_seq.sv
// Bench for wvr_drain_seq: behavioural register file, queue-based reference
// model filled at command issue, and a negedge monitor that pops and compares.
module tb_wvr_drain_seq;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int W      = DATA_W + 1;
`ifdef WVR_SEQ_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [1:0]        cmd_vl = '0;
  logic [ADDR_W-1:0] cmd_stride_v = '0;
  logic [ADDR_W-1:0] wvr_ra;
  logic [DATA_W-1:0] wvr_rd;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err_vl;

  logic [DATA_W-1:0] rf [32];
  logic [W-1:0]      exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int ready_mode = 0;
  int pat_k = 0;
  logic rsv_expect = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  assign wvr_rd = rf[wvr_ra];

  wvr_drain_seq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_base   (cmd_base),
    .cmd_vl     (cmd_vl),
`ifdef WVR_SEQ_STRIDE_EN
    .cmd_stride (cmd_stride_v),
`endif
    .wvr_ra     (wvr_ra),
    .wvr_rd     (wvr_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err_vl     (err_vl)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // downstream ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          out_ready = (pat_k % 3 == 0);
          pat_k++;
        end
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // scoreboard monitor
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  logic [ADDR_W-1:0] prev_ra;

  always @(negedge clk) begin : mon
    logic         exp_done;
    logic [W-1:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      exp_done = rsv_expect;
      if (out_valid && out_ready) begin
        beat_cnt++;
        chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e[DATA_W-1:0]));
          chk("out_last", 64'(out_last), 64'(e[DATA_W]));
          exp_done = e[DATA_W];
        end
      end
      chk("done", 64'(done), 64'(exp_done));
      chk("err_vl", 64'(err_vl), 64'(rsv_expect));
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_last", 64'(out_last), 64'(prev_last));
        chk("stall_ra", 64'(wvr_ra), 64'(prev_ra));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_ra    = wvr_ra;
    end
  end

  // driver tasks
  task automatic issue(input logic [4:0] base, input logic [1:0] vl, input logic [4:0] stride);
    int n;
    int t;
    int a;
    logic [4:0] s;
    s = STRIDE_EN ? stride : 5'd1;
    n = (vl == 2'b00) ? 1 : (vl == 2'b01) ? 4 : (vl == 2'b10) ? 16 : 0;
    t = 0;
    while (!cmd_ready && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("cmd_ready_before_issue", 64'(cmd_ready), 64'(1));
    for (int i = 0; i < n; i++) begin
      a = (int'(base) + i * int'(s)) % 32;
      exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, rf[a]});
    end
    cmd_base     = base;
    cmd_vl       = vl;
    cmd_stride_v = s;
    cmd_valid    = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    cmd_base     = 5'($urandom);
    cmd_vl       = 2'($urandom);
    cmd_stride_v = 5'($urandom);
    if (vl == 2'b11) begin
      rsv_expect = 1'b1;
      chk("rsv_busy", 64'(busy), 64'(1));
      chk("rsv_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rsv_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      rsv_expect = 1'b0;
      chk("rsv_cmd_ready_back", 64'(cmd_ready), 64'(1));
      chk("rsv_busy_low", 64'(busy), 64'(0));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && t < 600) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'(0));
    chk("drain_cmd_ready", 64'(cmd_ready), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_data"}, 64'(out_data), 64'(0));
    chk({tag, "_out_last"}, 64'(out_last), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err_vl"}, 64'(err_vl), 64'(0));
    chk({tag, "_wvr_ra"}, 64'(wvr_ra), 64'(0));
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < 32; k++) rf[k] = DATA_W'(k * 32'h11);
  endtask

  // main sequence
  initial begin
    int dc;
    int t;
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single element, latency check
    ready_mode = 0;
    rf[3] = 32'hA5;
    issue(5'd3, 2'b00, 5'd1);
    chk("t1_cycle1_out_valid", 64'(out_valid), 64'(0));
    chk("t1_cycle1_busy", 64'(busy), 64'(1));
    @(posedge clk);
    #1;
    chk("t1_cycle2_out_valid", 64'(out_valid), 64'(1));
    chk("t1_cycle2_done", 64'(done), 64'(1));
    chk("t1_cycle2_busy", 64'(busy), 64'(0));
    chk("t1_cycle2_data", 64'(out_data), 64'h0A5);
    wait_drain();

    // four elements, commands while busy must be ignored
    fill_pattern();
    dc = done_cnt;
    issue(5'd4, 2'b01, 5'd1);
    cmd_valid = 1'b1;
    cmd_vl    = 2'b00;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    wait_drain();
    chk("t2_done_pulses", 64'(done_cnt - dc), 64'(1));

    // sixteen elements wrapping the register index
    dc = done_cnt;
    issue(5'd28, 2'b10, 5'd1);
    wait_drain();
    chk("t3_done_pulses", 64'(done_cnt - dc), 64'(1));

    // backpressure 1,0,0 pattern
    ready_mode = 1;
    pat_k = 0;
    issue(5'd8, 2'b01, 5'd1);
    wait_drain();
    issue(5'd30, 2'b10, 5'd1);
    wait_drain();
    ready_mode = 0;

    // reserved VL
    dc = done_cnt;
    issue(5'd1, 2'b11, 5'd1);
    wait_drain();
    chk("t5_done_pulses", 64'(done_cnt - dc), 64'(1));

    // reset in the middle of a 16-element command
    beat_cnt = 0;
    dc = done_cnt;
    issue(5'd0, 2'b10, 5'd1);
    t = 0;
    while (beat_cnt < 7 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("t6_reached_beat7", 64'(beat_cnt), 64'(7));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("t6_no_done", 64'(done_cnt - dc), 64'(0));
    issue(5'd5, 2'b01, 5'd1);
    wait_drain();
    chk("t6_after_done", 64'(done_cnt - dc), 64'(1));

    if (STRIDE_EN) begin
      issue(5'd0, 2'b01, 5'd2);
      wait_drain();
      issue(5'd20, 2'b10, 5'd0);
      wait_drain();
    end

    // randomized commands
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 32; k++) rf[k] = $urandom;
      ready_mode = $urandom_range(0, 2);
      issue(5'($urandom), 2'($urandom), 5'($urandom));
      wait_drain();
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
